// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_FETCH,
    IFU_HOLD,
    IFU_HALT
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/ifu_sat_ctr.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module ifu_sat_ctr #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches over req/ack, presents to decode over valid/ready.
// Optional misaligned-npc trap is enabled by defining IFU_ALIGN_CHECK_EN.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      npc_i,
  input  logic             halt_i,
  output logic [31:0]      pc_o,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      imem_rdata_i,
  output logic             inst_valid_o,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_pc_o,
  input  logic             inst_ready_i,
  output logic             halted_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic             misalign_o
`endif
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        commit;
  logic        stall;
  logic        npc_bad;
  logic        locked;

`ifdef IFU_ALIGN_CHECK_EN
  logic mis_q, mis_d;

  assign npc_bad = (npc_i[1:0] != 2'b00);
  assign locked  = mis_q;
  assign mis_d   = mis_q | (commit & npc_bad);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign misalign_o = mis_q;
`else
  assign npc_bad = 1'b0;
  assign locked  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    commit  = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IFU_IDLE: begin
        state_d = halt_i ? IFU_HALT : IFU_FETCH;
      end
      IFU_FETCH: begin
        // An issued request stays up until ack; halt is deliberately ignored here.
        if (imem_ack_i) begin
          inst_d  = imem_rdata_i;
          state_d = IFU_HOLD;
        end else begin
          stall = 1'b1;
        end
      end
      IFU_HOLD: begin
        if (inst_ready_i) begin
          commit = 1'b1;
          if (!npc_bad) begin
            pc_d = npc_i;
          end
          state_d = (halt_i || npc_bad) ? IFU_HALT : IFU_FETCH;
        end
      end
      IFU_HALT: begin
        if (!halt_i && !locked) begin
          state_d = IFU_FETCH;
        end
      end
      default: state_d = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IFU_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  ifu_sat_ctr #(
    .Width (CNT_W)
  ) u_instr_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (commit),
    .cnt_o (instr_cnt_o)
  );

  ifu_sat_ctr #(
    .Width (CNT_W)
  ) u_stall_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall),
    .cnt_o (stall_cnt_o)
  );

  // Every output is a register or a pure decode of state.
  assign pc_o         = pc_q;
  assign imem_addr_o  = pc_q;
  assign inst_pc_o    = pc_q;
  assign inst_o       = inst_q;
  assign imem_req_o   = (state_q == IFU_FETCH);
  assign inst_valid_o = (state_q == IFU_HOLD);
  assign halted_o     = (state_q == IFU_HALT);

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the MIPS core. Owns the architectural PC register, fetches the word at PC from instruction memory over a req/ack handshake, and presents it to decode with a valid/ready handshake. The PC advances to the `npc` value from next-PC logic only when decode accepts the instruction. `npc` is computed combinationally from this block's `pc` and the decoded instruction.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `CNT_W`, default 32: width of the performance counters.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `npc`  in  32  next PC from next-PC logic; sampled only on commit.
- `halt`  in  1  request to stop fetching; level-sensitive.
- `pc`  out  32  current PC register; drives next-PC logic.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equal to `pc`.
- `imem_ack`  in  1  memory returns data this cycle; ignored unless `imem_req`=1.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack`=1.
- `inst_valid`  out  1  `inst` and `inst_pc` are valid.
- `inst`  out  32  fetched instruction, registered.
- `inst_pc`  out  32  address of `inst`, which is always equal to `pc` while `inst_valid`=1.
- `inst_ready`  in  1  decode accepts `inst` this cycle.
- `halted`  out  1  FSM is in HALT.
- `instr_cnt`  out  CNT_W  count of committed instructions, saturating.
- `stall_cnt`  out  CNT_W  count of cycles in FETCH without ack, saturating.
- `misalign`  out  1  sticky flag for a misaligned `npc` (present only with `IFU_ALIGN_CHECK_EN`).

## Operation
- States:
  - IDLE: one cycle after reset.
  - FETCH: `imem_req`=1.
  - HOLD: `inst_valid`=1.
  - HALT: no request outstanding.
- IDLE → HALT if `halt`=1, else → FETCH.
- FETCH: `imem_req` is held at 1 and `imem_addr` held at `pc` until `imem_ack`=1.
  - On ack: `inst` <= `imem_rdata`, then → HOLD.
  - `halt` is ignored in FETCH; an issued request is never withdrawn except by `rst`.
- HOLD: `inst` is held stable while `inst_ready`=0.
  - Commit is `inst_valid`&&`inst_ready`.
  - On commit: `pc` <= `npc` and `instr_cnt`++.
  - After commit: → HALT if `halt`=1, else → FETCH.
- HALT: `imem_req`=0, `inst_valid`=0, `pc` frozen. Leaves to FETCH on the first cycle with `halt`=0.
- `stall_cnt` increments each FETCH cycle with `imem_ack`=0.
- Both counters saturate at all-ones and do not wrap.
- `pc` arithmetic is done outside this block; `pc` wraps only if `npc` wraps.

## Timing
- Reset values:
  - `pc`=RESET_PC, state IDLE.
  - `imem_req`=0, `inst_valid`=0, `inst`=0, `halted`=0.
  - Counters 0, `misalign`=0.
- `rst` asserted in any state (including mid-fetch) forces the reset values next edge. An abandoned request is dropped; memory must tolerate a request withdrawn by reset.
- Same-cycle ack: FETCH and ack in cycle n give `inst_valid`=1 in cycle n+1.
- Peak throughput is 1 instruction per 2 cycles (FETCH, HOLD). Each wait cycle without ack adds 1 cycle.
- Commit in cycle n: new `pc` is visible and `imem_req`=1 in cycle n+1.
- `halt` asserted in the same cycle as commit: that instruction commits, then → HALT. `halted`=1 from the next cycle.
- `halt` deasserted in HALT in cycle n: `imem_req`=1 in cycle n+1.
- All outputs are registered or decoded from state only. There are no combinational paths from `imem_ack` or `inst_ready` to any output.

## Configuration
- `IFU_ALIGN_CHECK_EN` defined:
  - A commit with `npc[1:0]`≠0 does not update `pc`.
  - It sets sticky `misalign`=1, still counts as a commit, and goes to HALT.
  - HALT is left only by `rst`.
- `IFU_ALIGN_CHECK_EN` undefined:
  - `misalign` port is absent.
  - `pc` <= `npc` unconditionally on commit; low bits pass through unchanged.

## Structure
- Package `ifu_pkg` holds:
  - the state enum (`IFU_IDLE`, `IFU_FETCH`, `IFU_HOLD`, `IFU_HALT`);
  - the default reset PC constant 32'h0000_3000.
- Sub-module `ifu_sat_ctr`: saturating counter (width param, `inc` input), instantiated twice for `instr_cnt` and `stall_cnt`.

## Test plan
- Reset, ack tied 1, ready tied 1, `npc`=`pc`+4: req in cycle 1; `inst_valid` on cycles 2, 4, 6; `inst_pc`=3000, 3004, 3008; `instr_cnt`=3 after cycle 6.
- Ack delayed 3 cycles on the first fetch: req held with addr 3000 for 4 cycles; `stall_cnt`=3; `inst` = rdata of the ack cycle.
- Ready held 0 for 5 cycles in HOLD, `npc` toggled meanwhile: `inst` stable, `pc` unchanged; `pc` takes `npc` from the ready cycle only.
- `halt`=1 on the commit cycle: `halted`=1 next cycle, `imem_req`=0; deassert `halt` → req at the new PC one cycle later.
- `rst` pulsed in FETCH with ack pending: next cycle `pc`=3000, req=0, state IDLE, counters 0.
- With `IFU_ALIGN_CHECK_EN`, commit `npc`=32'h0000_3006: `misalign`=1, `pc` stays 3000, `halted`=1; deasserting `halt` does not restart fetch.
